// File: rtl/idu_issue_pkg.sv
`default_nettype none
// ============================================================================
// idu_issue_pkg : shared widths, opcode constants and decode codes for IDU
// Rev 1.0 - initial release
// ============================================================================
package idu_issue_pkg;

  localparam int INST_TYPE_W = 3;
  localparam int ALU_OP_W    = 4;
  localparam int REG_DATA_W  = 32;
  localparam int INST_ADDR_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [INST_TYPE_W-1:0] {
    INST_NOP   = 3'd0,
    INST_RR    = 3'd1,
    INST_RI    = 3'd2,
    INST_LUI   = 3'd3,
    INST_AUIPC = 3'd4,
    INST_JAL   = 3'd5,
    INST_JALR  = 3'd6
  } inst_type_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_NOP   = 4'd0,
    ALU_OP_ADD   = 4'd1,
    ALU_OP_SUB   = 4'd2,
    ALU_OP_SLL   = 4'd3,
    ALU_OP_SLT   = 4'd4,
    ALU_OP_SLTU  = 4'd5,
    ALU_OP_XOR   = 4'd6,
    ALU_OP_SRL   = 4'd7,
    ALU_OP_SRA   = 4'd8,
    ALU_OP_OR    = 4'd9,
    ALU_OP_AND   = 4'd10,
    ALU_OP_LUI   = 4'd11,
    ALU_OP_AUIPC = 4'd12,
    ALU_OP_JUMP  = 4'd13
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic [INST_TYPE_W-1:0] inst_type;
    logic [ALU_OP_W-1:0]    alu_op;
    logic [INST_ADDR_W-1:0] pc;
    logic [REG_DATA_W-1:0]  imm;
    logic [REG_DATA_W-1:0]  rdata1;
    logic [REG_DATA_W-1:0]  rdata2;
    logic [4:0]             rd;
    logic                   wen;
    logic                   illegal;
  } payload_t;

  // Base ALU op for funct3 when funct7 carries no alternate-op bit.
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_OP_ADD;
      3'b001:  op = ALU_OP_SLL;
      3'b010:  op = ALU_OP_SLT;
      3'b011:  op = ALU_OP_SLTU;
      3'b100:  op = ALU_OP_XOR;
      3'b101:  op = ALU_OP_SRL;
      3'b110:  op = ALU_OP_OR;
      default: op = ALU_OP_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/idu_decode.sv
`default_nettype none
// ============================================================================
// idu_decode : combinational RV32I ALU/LUI/AUIPC/JAL/JALR decoder
// Rev 1.0 - initial release
// ============================================================================
module idu_decode
  import idu_issue_pkg::*;
(
  input  logic [31:0]            inst_i,
  output logic [INST_TYPE_W-1:0] inst_type_o,
  output logic [ALU_OP_W-1:0]    alu_op_o,
  output logic [REG_DATA_W-1:0]  imm_o,
  output logic [4:0]             rd_o,
  output logic                   wen_o,
  output logic                   illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i_type;
  logic [31:0] imm_u_type;
  logic [31:0] imm_j_type;
  logic [31:0] imm_shamt;
  logic        is_shift_imm;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign funct7     = inst_i[31:25];
  assign imm_i_type = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_u_type = {inst_i[31:12], 12'b0};
  assign imm_j_type = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                       inst_i[20], inst_i[30:21], 1'b0};
  assign imm_shamt  = {27'b0, inst_i[24:20]};
  assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign rd_o       = inst_i[11:7];

  always_comb begin
    inst_type_o = INST_NOP;
    alu_op_o    = ALU_OP_NOP;
    imm_o       = '0;
    wen_o       = 1'b0;
    illegal_o   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          inst_type_o = INST_RR;
          alu_op_o    = base_op(funct3);
          wen_o       = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          inst_type_o = INST_RR;
          alu_op_o    = ALU_OP_SUB;
          wen_o       = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          inst_type_o = INST_RR;
          alu_op_o    = ALU_OP_SRA;
          wen_o       = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // Shift immediates reuse the upper I-imm bits as funct7; only shamt is kept.
        if (!is_shift_imm) begin
          inst_type_o = INST_RI;
          alu_op_o    = base_op(funct3);
          imm_o       = imm_i_type;
          wen_o       = 1'b1;
        end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          inst_type_o = INST_RI;
          alu_op_o    = (funct3 == 3'b101 && funct7 == F7_ALT) ? ALU_OP_SRA
                                                                : base_op(funct3);
          imm_o       = imm_shamt;
          wen_o       = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_LUI: begin
        inst_type_o = INST_LUI;
        alu_op_o    = ALU_OP_LUI;
        imm_o       = imm_u_type;
        wen_o       = 1'b1;
      end
      OPC_AUIPC: begin
        inst_type_o = INST_AUIPC;
        alu_op_o    = ALU_OP_AUIPC;
        imm_o       = imm_u_type;
        wen_o       = 1'b1;
      end
      OPC_JAL: begin
        inst_type_o = INST_JAL;
        alu_op_o    = ALU_OP_JUMP;
        imm_o       = imm_j_type;
        wen_o       = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          inst_type_o = INST_JALR;
          alu_op_o    = ALU_OP_JUMP;
          imm_o       = imm_i_type;
          wen_o       = 1'b1;
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/idu_issue.sv
`default_nettype none
// ============================================================================
// idu_issue : decode-and-issue stage with a single-entry skid-free output reg
// Rev 1.0 - initial release
// ============================================================================
module idu_issue
  import idu_issue_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [31:0]            inst_i,
  input  logic [INST_ADDR_W-1:0] pc_i,
  output logic [4:0]             raddr1_o,
  output logic [4:0]             raddr2_o,
  input  logic [REG_DATA_W-1:0]  rdata1_i,
  input  logic [REG_DATA_W-1:0]  rdata2_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [INST_TYPE_W-1:0] inst_type_o,
  output logic [ALU_OP_W-1:0]    alu_op_o,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [REG_DATA_W-1:0]  imm_o,
  output logic [REG_DATA_W-1:0]  rdata1_o,
  output logic [REG_DATA_W-1:0]  rdata2_o,
  output logic [4:0]             rd_o,
  output logic                   wen_o,
  output logic                   illegal_o
);

  issue_state_e state_q, state_d;
  payload_t     payload_q, payload_d;

  logic [INST_TYPE_W-1:0] dec_inst_type;
  logic [ALU_OP_W-1:0]    dec_alu_op;
  logic [REG_DATA_W-1:0]  dec_imm;
  logic [4:0]             dec_rd;
  logic                   dec_wen;
  logic                   dec_illegal;
  logic                   accept;

  idu_decode u_decode (
    .inst_i      (inst_i),
    .inst_type_o (dec_inst_type),
    .alu_op_o    (dec_alu_op),
    .imm_o       (dec_imm),
    .rd_o        (dec_rd),
    .wen_o       (dec_wen),
    .illegal_o   (dec_illegal)
  );

  assign raddr1_o = inst_i[19:15];
  assign raddr2_o = inst_i[24:20];

  // ready_i passes straight through so a draining entry can be replaced in the same cycle.
  assign ready_o = (state_q == ST_EMPTY) || ready_i;
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && ready_i) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_comb begin
    payload_d = payload_q;
    if (accept) begin
      payload_d.inst_type = dec_inst_type;
      payload_d.alu_op    = dec_alu_op;
      payload_d.pc        = pc_i;
      payload_d.imm       = dec_imm;
      payload_d.rdata1    = rdata1_i;
      payload_d.rdata2    = rdata2_i;
      payload_d.rd        = dec_rd;
      payload_d.wen       = dec_wen;
      payload_d.illegal   = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= ST_EMPTY;
      payload_q           <= '0;
      payload_q.inst_type <= INST_NOP;
      payload_q.alu_op    <= ALU_OP_NOP;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o     = (state_q == ST_FULL);
  assign inst_type_o = payload_q.inst_type;
  assign alu_op_o    = payload_q.alu_op;
  assign pc_o        = payload_q.pc;
  assign imm_o       = payload_q.imm;
  assign rdata1_o    = payload_q.rdata1;
  assign rdata2_o    = payload_q.rdata2;
  assign rd_o        = payload_q.rd;
  assign wen_o       = payload_q.wen;
  assign illegal_o   = payload_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_idu_issue.sv
`default_nettype none
// ============================================================================
// tb_idu_issue : directed + randomized bench for idu_issue with reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_idu_issue;
  import idu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, ready_i;
  logic [31:0] inst_i, pc_i, rdata1_i, rdata2_i;
  logic        ready_o, valid_o, wen_o, illegal_o;
  logic [4:0]  raddr1_o, raddr2_o, rd_o;
  logic [2:0]  inst_type_o;
  logic [3:0]  alu_op_o;
  logic [31:0] pc_o, imm_o, rdata1_o, rdata2_o;

  always #5 clk = ~clk;

  idu_issue dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .valid_o(valid_o), .ready_i(ready_i),
    .inst_type_o(inst_type_o), .alu_op_o(alu_op_o), .pc_o(pc_o), .imm_o(imm_o),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .rd_o(rd_o), .wen_o(wen_o),
    .illegal_o(illegal_o)
  );

  typedef struct packed {
    logic [2:0]  ty;
    logic [3:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } dec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  f3_op [0:7];
  logic        m_known = 1'b0;
  logic        m_valid = 1'b0;
  dec_t        m_dec;
  logic [31:0] m_pc, m_r1, m_r2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    f7 = w[31:25];
    f3 = w[14:12];
    ok = 1'b0;
    d  = '0;
    d.rd = w[11:7];
    if (w[6:0] == 7'b0110011) begin
      d.ty = INST_RR;
      if (f7 == 7'h00) begin ok = 1'b1; d.op = f3_op[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; d.op = ALU_OP_SUB; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; d.op = ALU_OP_SRA; end
    end else if (w[6:0] == 7'b0010011) begin
      d.ty = INST_RI;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        d.imm = 32'(w[24:20]);
        if (f7 == 7'h00) begin ok = 1'b1; d.op = f3_op[f3]; end
        else if (f7 == 7'h20) begin ok = 1'b1; d.op = (f3 == 3'd5) ? ALU_OP_SRA : ALU_OP_SLL; end
      end else begin
        ok = 1'b1; d.op = f3_op[f3];
        d.imm = 32'($signed(w[31:20]));
      end
    end else if (w[6:0] == 7'b0110111) begin
      ok = 1'b1; d.ty = INST_LUI; d.op = ALU_OP_LUI; d.imm = w & 32'hFFFF_F000;
    end else if (w[6:0] == 7'b0010111) begin
      ok = 1'b1; d.ty = INST_AUIPC; d.op = ALU_OP_AUIPC; d.imm = w & 32'hFFFF_F000;
    end else if (w[6:0] == 7'b1101111) begin
      ok = 1'b1; d.ty = INST_JAL; d.op = ALU_OP_JUMP;
      d.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    end else if (w[6:0] == 7'b1100111 && f3 == 3'd0) begin
      ok = 1'b1; d.ty = INST_JALR; d.op = ALU_OP_JUMP;
      d.imm = 32'($signed(w[31:20]));
    end
    if (ok) d.wen = 1'b1;
    else begin d.ty = INST_NOP; d.op = ALU_OP_NOP; d.imm = '0; d.ill = 1'b1; end
    return d;
  endfunction

  // One clock of stimulus: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic rdy, input logic fl, input logic rs);
    logic exp_ready, acc;
    valid_i = v; inst_i = inst; pc_i = pc; rdata1_i = d1; rdata2_i = d2;
    ready_i = rdy; flush_i = fl; rst = rs;
    #1;
    exp_ready = !m_valid || rdy;
    if (m_known) chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("raddr1_o", 32'(raddr1_o), 32'(inst[19:15]));
    chk("raddr2_o", 32'(raddr2_o), 32'(inst[24:20]));
    acc = v && exp_ready && !fl;
    @(posedge clk);
    if (rs) begin
      m_known = 1'b1; m_valid = 1'b0; m_dec = '0; m_pc = '0; m_r1 = '0; m_r2 = '0;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_dec = ref_decode(inst); m_pc = pc; m_r1 = d1; m_r2 = d2;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    chk("valid_o",     32'(valid_o),     32'(m_valid));
    chk("inst_type_o", 32'(inst_type_o), 32'(m_dec.ty));
    chk("alu_op_o",    32'(alu_op_o),    32'(m_dec.op));
    chk("pc_o",        pc_o,             m_pc);
    chk("imm_o",       imm_o,            m_dec.imm);
    chk("rdata1_o",    rdata1_o,         m_r1);
    chk("rdata2_o",    rdata2_o,         m_r2);
    chk("rd_o",        32'(rd_o),        32'(m_dec.rd));
    chk("wen_o",       32'(wen_o),       32'(m_dec.wen));
    chk("illegal_o",   32'(illegal_o),   32'(m_dec.ill));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  f7;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 8);
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case (k)
      0: begin w[6:0] = 7'b0110011; w[31:25] = f7; end
      1: w[6:0] = 7'b0010011;
      2: begin w[6:0] = 7'b0010011; w[13:12] = 2'b01; w[31:25] = f7; end
      3: w[6:0] = 7'b0110111;
      4: w[6:0] = 7'b0010111;
      5: w[6:0] = 7'b1101111;
      6: begin w[6:0] = 7'b1100111; if ($urandom_range(0, 2) != 0) w[14:12] = 3'd0; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    f3_op[0] = ALU_OP_ADD;  f3_op[1] = ALU_OP_SLL; f3_op[2] = ALU_OP_SLT; f3_op[3] = ALU_OP_SLTU;
    f3_op[4] = ALU_OP_XOR;  f3_op[5] = ALU_OP_SRL; f3_op[6] = ALU_OP_OR;  f3_op[7] = ALU_OP_AND;
    m_dec = '0; m_pc = '0; m_r1 = '0; m_r2 = '0;
    rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    inst_i = '0; pc_i = '0; rdata1_i = '0; rdata2_i = '0;
    @(negedge clk);

    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 1);
    chk("reset_type", 32'(inst_type_o), 32'(INST_NOP));
    chk("reset_ready", 32'(ready_o), 32'd1);

    step(1, 32'h00500093, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);
    chk("addi_valid", 32'(valid_o), 32'd1);
    chk("addi_type", 32'(inst_type_o), 32'(INST_RI));
    chk("addi_op", 32'(alu_op_o), 32'(ALU_OP_ADD));
    chk("addi_imm", imm_o, 32'd5);
    chk("addi_rd", 32'(rd_o), 32'd1);
    chk("addi_pc", pc_o, 32'h8000_0000);

    step(1, 32'h12345137, 32'h8000_0004, 32'h0, 32'h0, 1, 0, 0);
    chk("lui_imm", imm_o, 32'h1234_5000);
    step(1, 32'h402081B3, 32'h8000_0008, 32'd7, 32'd2, 1, 0, 0);
    chk("sub_op", 32'(alu_op_o), 32'(ALU_OP_SUB));
    chk("sub_rdata1", rdata1_o, 32'd7);
    chk("sub_rdata2", rdata2_o, 32'd2);
    step(1, 32'h40335293, 32'h8000_000C, 32'h0, 32'h0, 1, 0, 0);
    chk("srai_op", 32'(alu_op_o), 32'(ALU_OP_SRA));
    chk("srai_imm", imm_o, 32'd3);

    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00900393, 32'h8000_0010, 32'h0, 32'h0, 0, 0, 0);
      chk("stall_pc", pc_o, 32'h8000_000C);
    end
    step(1, 32'h00900393, 32'h8000_0010, 32'h0, 32'h0, 1, 0, 0);
    chk("release_pc", pc_o, 32'h8000_0010);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    chk("drained_valid", 32'(valid_o), 32'd0);

    step(1, 32'h00000000, 32'h8000_0014, 32'h0, 32'h0, 0, 0, 0);
    chk("illegal_flag", 32'(illegal_o), 32'd1);
    chk("illegal_wen", 32'(wen_o), 32'd0);
    chk("illegal_valid", 32'(valid_o), 32'd1);

    step(1, 32'h12345137, 32'h8000_0018, 32'h0, 32'h0, 0, 1, 0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    step(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);

    step(1, 32'h00500093, 32'h8000_001C, 32'h1, 32'h2, 0, 0, 0);
    step(1, 32'h12345137, 32'h8000_0020, 32'h1, 32'h2, 0, 0, 1);
    chk("rst_full_valid", 32'(valid_o), 32'd0);
    chk("rst_full_pc", pc_o, 32'h0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), rand_inst(), $urandom, $urandom, $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
